// File: rtl/wide_alu_seq.sv
// Byte-serial sequencer for a 32-bit add/sub/shift built around an external
// 8-bit ALU: one byte per cycle, carry or shift bit chained through a register.
module wide_alu_seq #(
  parameter int MAXB = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                START,
  input  logic [1:0]          CMD,
  input  logic [1:0]          LEN,
  input  logic [8*MAXB-1:0]   A_IN,
  input  logic [8*MAXB-1:0]   B_IN,
  output logic [7:0]          ALU_A,
  output logic [7:0]          ALU_B,
  output logic [2:0]          ALU_OP,
  output logic [2:0]          ALU_FUNC,
  output logic                ALU_OVF_IN,
  input  logic [7:0]          ALU_OUT,
  input  logic                ALU_OVF_OUT,
  output logic                BUSY,
  output logic                DONE,
  output logic [8*MAXB-1:0]   RESULT,
  output logic                CARRY_OUT,
  output logic                ZERO
);

  localparam int W = 8 * MAXB;

  // ALU definitions shared with the ALU block
  localparam logic [2:0] OP_ADD      = 3'b001;
  localparam logic [2:0] OP_SUB      = 3'b010;
  localparam logic [2:0] OP_OTYPE    = 3'b100;
  localparam logic [2:0] FN_SHIFTL_O = 3'b001;
  localparam logic [2:0] FN_SHIFTR_O = 3'b010;

  localparam logic [1:0] CMD_ADD = 2'b00;
  localparam logic [1:0] CMD_SUB = 2'b01;
  localparam logic [1:0] CMD_SHL = 2'b10;
  localparam logic [1:0] CMD_SHR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t       state_r, state_s;
  logic [1:0]   cmd_r, len_r, idx_r, idx_next_s;
  logic [W-1:0] a_r, b_r, result_r, result_s;
  logic         carry_r, carry_out_r, zero_r, busy_r, done_r;
  logic         accept_s, run_s, last_s;

  // True when bytes 0..len of v are all zero; bytes above len are ignored.
  function automatic logic bytes_zero(input logic [W-1:0] v, input logic [1:0] len);
    logic z;
    z = 1'b1;
    for (int i = 0; i < MAXB; i++) begin
      if ((i <= int'(len)) && (v[8*i +: 8] != 8'd0)) begin
        z = 1'b0;
      end
    end
    return z;
  endfunction

  assign run_s    = (state_r == S_RUN);
  assign accept_s = (state_r == S_IDLE) && START;

  // Byte-walk bookkeeping: last-byte detect, next index, result with current byte merged.
  always_comb begin
    last_s     = 1'b0;
    idx_next_s = idx_r;
    result_s   = result_r;
    if (cmd_r == CMD_SHR) begin
      last_s     = (idx_r == 2'd0);
      idx_next_s = idx_r - 2'd1;
    end else begin
      last_s     = (idx_r == len_r);
      idx_next_s = idx_r + 2'd1;
    end
    result_s[{idx_r, 3'b000} +: 8] = ALU_OUT;
  end

  // Next-state logic for IDLE -> RUN -> DONE -> IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (START) state_s = S_RUN;
        else       state_s = S_IDLE;
      end
      S_RUN: begin
        if (last_s) state_s = S_DONE;
        else        state_s = S_RUN;
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state_r <= S_IDLE;
    else       state_r <= state_s;
  end

  // Operand latch, byte index, chained carry, result and status registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cmd_r       <= 2'd0;
      len_r       <= 2'd0;
      idx_r       <= 2'd0;
      a_r         <= '0;
      b_r         <= '0;
      result_r    <= '0;
      carry_r     <= 1'b0;
      carry_out_r <= 1'b0;
      zero_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      busy_r <= (state_s == S_RUN);
      done_r <= (state_s == S_DONE);
      if (accept_s) begin
        cmd_r       <= CMD;
        len_r       <= LEN;
        a_r         <= A_IN;
        b_r         <= B_IN;
        idx_r       <= (CMD == CMD_SHR) ? LEN : 2'd0;
        result_r    <= '0;
        carry_r     <= 1'b0;
        carry_out_r <= 1'b0;
        zero_r      <= 1'b0;
      end else if (run_s) begin
        result_r <= result_s;
        carry_r  <= ALU_OVF_OUT;
        idx_r    <= idx_next_s;
        if (last_s) begin
          carry_out_r <= ALU_OVF_OUT;
          zero_r      <= bytes_zero(result_s, len_r);
        end
      end
    end
  end

  // ALU drive: active only in RUN so the ALU sits idle otherwise.
  always_comb begin
    ALU_A      = 8'd0;
    ALU_B      = 8'd0;
    ALU_OP     = 3'd0;
    ALU_FUNC   = 3'd0;
    ALU_OVF_IN = 1'b0;
    if (run_s) begin
      ALU_A      = a_r[{idx_r, 3'b000} +: 8];
      ALU_B      = b_r[{idx_r, 3'b000} +: 8];
      ALU_OVF_IN = carry_r;
      case (cmd_r)
        CMD_ADD: ALU_OP = OP_ADD;
        CMD_SUB: ALU_OP = OP_SUB;
        CMD_SHL: begin
          ALU_OP   = OP_OTYPE;
          ALU_FUNC = FN_SHIFTL_O;
        end
        CMD_SHR: begin
          ALU_OP   = OP_OTYPE;
          ALU_FUNC = FN_SHIFTR_O;
        end
        default: ALU_OP = 3'd0;
      endcase
    end else begin
      ALU_OVF_IN = 1'b0;
    end
  end

  assign BUSY      = busy_r;
  assign DONE      = done_r;
  assign RESULT    = result_r;
  assign CARRY_OUT = carry_out_r;
  assign ZERO      = zero_r;

endmodule

// File: tb/tb_wide_alu_seq.sv
// Bench for wide_alu_seq: models the external 8-bit ALU, runs a vector table
// through a scoreboard and adds hand sequences for reset, re-START and held START.
module tb_wide_alu_seq;

  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_OTYPE = 3'b100;
  localparam logic [2:0] FN_SHL   = 3'b001;
  localparam logic [2:0] FN_SHR   = 3'b010;

  logic        CLK, RESET, START;
  logic [1:0]  CMD, LEN;
  logic [31:0] A_IN, B_IN;
  logic [7:0]  ALU_A, ALU_B, ALU_OUT;
  logic [2:0]  ALU_OP, ALU_FUNC;
  logic        ALU_OVF_IN, ALU_OVF_OUT;
  logic        BUSY, DONE, CARRY_OUT, ZERO;
  logic [31:0] RESULT;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0]  cmd;
    logic [1:0]  len;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        cy;
    logic        z;
  } vec_t;

  vec_t vecs[9];
  vec_t sb[$];

  wide_alu_seq #(.MAXB(4)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .CMD(CMD), .LEN(LEN),
    .A_IN(A_IN), .B_IN(B_IN), .ALU_A(ALU_A), .ALU_B(ALU_B),
    .ALU_OP(ALU_OP), .ALU_FUNC(ALU_FUNC), .ALU_OVF_IN(ALU_OVF_IN),
    .ALU_OUT(ALU_OUT), .ALU_OVF_OUT(ALU_OVF_OUT), .BUSY(BUSY), .DONE(DONE),
    .RESULT(RESULT), .CARRY_OUT(CARRY_OUT), .ZERO(ZERO)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // External ALU model: chained add/sub with carry/borrow, 1-bit shifts through OVERFLOW.
  always_comb begin
    ALU_OUT     = 8'd0;
    ALU_OVF_OUT = 1'b0;
    case (ALU_OP)
      OP_ADD: {ALU_OVF_OUT, ALU_OUT} = {1'b0, ALU_A} + {1'b0, ALU_B} + {8'd0, ALU_OVF_IN};
      OP_SUB: {ALU_OVF_OUT, ALU_OUT} = {1'b0, ALU_A} - {1'b0, ALU_B} - {8'd0, ALU_OVF_IN};
      OP_OTYPE: begin
        if (ALU_FUNC == FN_SHL) begin
          ALU_OUT     = {ALU_A[6:0], ALU_OVF_IN};
          ALU_OVF_OUT = ALU_A[7];
        end else if (ALU_FUNC == FN_SHR) begin
          ALU_OUT     = {ALU_OVF_IN, ALU_A[7:1]};
          ALU_OVF_OUT = ALU_A[0];
        end
      end
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [2:0] exp_op(input logic [1:0] cmd);
    case (cmd)
      2'b00:   return OP_ADD;
      2'b01:   return OP_SUB;
      default: return OP_OTYPE;
    endcase
  endfunction

  function automatic logic [2:0] exp_func(input logic [1:0] cmd);
    case (cmd)
      2'b10:   return FN_SHL;
      2'b11:   return FN_SHR;
      default: return 3'd0;
    endcase
  endfunction

  // mode 0: plain; 1: scramble inputs after accept; 2: re-pulse START with new operands while busy
  task automatic run_vec(input vec_t v, input int mode);
    int   cyc;
    vec_t e;
    logic [7:0] first;
    START = 1'b1; CMD = v.cmd; LEN = v.len; A_IN = v.a; B_IN = v.b;
    sb.push_back(v);
    tick();
    cyc = 1;
    START = 1'b0;
    if (mode == 1) begin
      A_IN = $urandom; B_IN = $urandom; CMD = 2'($urandom); LEN = 2'($urandom);
    end
    first = (v.cmd == 2'b11) ? v.a[{v.len, 3'b000} +: 8] : v.a[7:0];
    chk("first_byte", 32'(ALU_A), 32'(first));
    chk("first_cin", 32'(ALU_OVF_IN), 32'd0);
    while (DONE !== 1'b1 && cyc < 12) begin
      chk("busy", 32'(BUSY), 32'd1);
      chk("alu_op", 32'(ALU_OP), 32'(exp_op(v.cmd)));
      chk("alu_func", 32'(ALU_FUNC), 32'(exp_func(v.cmd)));
      if (mode == 2 && cyc == 1) begin
        START = 1'b1; A_IN = 32'h11111111; B_IN = 32'h22222222; CMD = 2'b01; LEN = 2'd0;
      end else begin
        START = 1'b0;
      end
      tick();
      cyc++;
    end
    START = 1'b0;
    chk("done_cycle", 32'(cyc), 32'(int'(v.len) + 2));
    chk("busy_in_done", 32'(BUSY), 32'd0);
    e = v;
    if (sb.size() > 0) e = sb.pop_front();
    chk("result", RESULT, e.res);
    chk("carry_out", 32'(CARRY_OUT), 32'(e.cy));
    chk("zero", 32'(ZERO), 32'(e.z));
    tick();
    chk("done_pulse_width", 32'(DONE), 32'd0);
    chk("idle_busy", 32'(BUSY), 32'd0);
    chk("result_held", RESULT, e.res);
    chk("carry_held", 32'(CARRY_OUT), 32'(e.cy));
    chk("idle_alu_op", 32'(ALU_OP), 32'd0);
    chk("idle_alu_a", 32'(ALU_A), 32'd0);
  endtask

  initial begin
    vecs[0] = '{cmd: 2'b00, len: 2'd1, a: 32'h000000FF, b: 32'h00000001, res: 32'h00000100, cy: 1'b0, z: 1'b0};
    vecs[1] = '{cmd: 2'b00, len: 2'd3, a: 32'hFFFFFFFF, b: 32'h00000001, res: 32'h00000000, cy: 1'b1, z: 1'b1};
    vecs[2] = '{cmd: 2'b10, len: 2'd1, a: 32'h00008081, b: 32'h00000000, res: 32'h00000102, cy: 1'b1, z: 1'b0};
    vecs[3] = '{cmd: 2'b11, len: 2'd1, a: 32'h00000181, b: 32'h00000000, res: 32'h000000C0, cy: 1'b1, z: 1'b0};
    vecs[4] = '{cmd: 2'b00, len: 2'd0, a: 32'h0000AB12, b: 32'h00000001, res: 32'h00000013, cy: 1'b0, z: 1'b0};
    vecs[5] = '{cmd: 2'b01, len: 2'd1, a: 32'h00000100, b: 32'h00000001, res: 32'h000000FF, cy: 1'b0, z: 1'b0};
    vecs[6] = '{cmd: 2'b01, len: 2'd0, a: 32'h00000000, b: 32'h00000001, res: 32'h000000FF, cy: 1'b1, z: 1'b0};
    vecs[7] = '{cmd: 2'b11, len: 2'd3, a: 32'h80000001, b: 32'h00000000, res: 32'h40000000, cy: 1'b1, z: 1'b0};
    vecs[8] = '{cmd: 2'b10, len: 2'd3, a: 32'h80000000, b: 32'hFFFFFFFF, res: 32'h00000000, cy: 1'b1, z: 1'b1};

    RESET = 1'b1; START = 1'b0; CMD = 2'd0; LEN = 2'd0; A_IN = 32'd0; B_IN = 32'd0;
    tick();
    START = 1'b1; A_IN = 32'hDEADBEEF;
    tick();
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_result", RESULT, 32'd0);
    chk("rst_carry", 32'(CARRY_OUT), 32'd0);
    chk("rst_zero", 32'(ZERO), 32'd0);
    chk("rst_alu_op", 32'(ALU_OP), 32'd0);
    START = 1'b0; RESET = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], (i % 2 == 1) ? 1 : 0);
    end

    // START re-pulsed while busy must not disturb the running operation
    run_vec(vecs[1], 2);
    chk("repulse_not_accepted", 32'(BUSY), 32'd0);

    // Reset mid-run: abort with no DONE, everything back to zero
    START = 1'b1; CMD = 2'b00; LEN = 2'd3; A_IN = 32'h01020304; B_IN = 32'h01010101;
    tick();
    START = 1'b0;
    tick();
    RESET = 1'b1;
    tick();
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_done", 32'(DONE), 32'd0);
    chk("abort_result", RESULT, 32'd0);
    chk("abort_carry", 32'(CARRY_OUT), 32'd0);
    chk("abort_zero", 32'(ZERO), 32'd0);
    chk("abort_alu_a", 32'(ALU_A), 32'd0);
    chk("abort_alu_op", 32'(ALU_OP), 32'd0);
    RESET = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("abort_no_done", 32'(DONE), 32'd0);
      chk("abort_stays_idle", 32'(BUSY), 32'd0);
    end
    run_vec(vecs[0], 0);

    // START held high: ignored in DONE, re-accepted in the following IDLE cycle
    START = 1'b1; CMD = 2'b00; LEN = 2'd0; A_IN = 32'h00000001; B_IN = 32'h00000002;
    tick();
    chk("hold_c1_busy", 32'(BUSY), 32'd1);
    tick();
    chk("hold_c2_done", 32'(DONE), 32'd1);
    chk("hold_c2_result", RESULT, 32'h00000003);
    tick();
    chk("hold_c3_busy", 32'(BUSY), 32'd0);
    chk("hold_c3_done", 32'(DONE), 32'd0);
    chk("hold_c3_result", RESULT, 32'h00000003);
    tick();
    chk("hold_c4_busy", 32'(BUSY), 32'd1);
    chk("hold_c4_result_cleared", RESULT, 32'd0);
    START = 1'b0;
    tick();
    chk("hold_c5_done", 32'(DONE), 32'd1);
    chk("hold_c5_result", RESULT, 32'h00000003);
    tick();

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
